// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer: 32-step restoring divider with
// divide-by-zero and signed-overflow fast path, pipeline stall and flush support.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] div_r;
    logic            neg_q, neg_r, is_rem_r;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic signed [XLEN-1:0] op1_s, op2_s;
    logic            is_signed, is_rem, accept, div_zero, ovf, fast;
    logic [XLEN-1:0] abs1, abs2, fast_res;

    assign op1_s     = operand1;
    assign op2_s     = operand2;
    assign is_signed = ~op[0];
    assign is_rem    = op[1];
    assign accept    = start && (state == IDLE) && !flush;
    assign abs1      = cond_neg(operand1, is_signed && (op1_s < 0));
    assign abs2      = cond_neg(operand2, is_signed && (op2_s < 0));
    assign div_zero  = (operand2 == '0);
    assign ovf       = is_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
    assign fast      = div_zero || ovf;
    // Overflow quotient equals the dividend (most negative value); remainder is zero.
    assign fast_res  = div_zero ? (is_rem ? operand1 : '1) : (is_rem ? '0 : operand1);

    logic [XLEN:0]          shifted;
    logic signed [XLEN:0]   trial;
    logic [XLEN-1:0]        q_fix, r_fix;

    assign shifted = {rem_r[XLEN-1:0], quo_r[XLEN-1]};
    assign trial   = $signed(shifted - {1'b0, div_r});
    assign q_fix   = cond_neg(quo_r, neg_q);
    assign r_fix   = cond_neg(rem_r[XLEN-1:0], neg_r);

    assign stall = !reset && (accept || (state == ITER) || (state == FIXUP));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fast ? DONE : ITER;
            ITER:    if (flush) state_nxt = IDLE;
                     else if (cnt == CW'(XLEN-1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = flush ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt != IDLE);
            result_valid <= (state_nxt == DONE);
            if (accept)
                cnt <= '0;
            else if (state == ITER)
                cnt <= cnt + CW'(1);
            if (accept && fast)
                result <= fast_res;
            else if (state == FIXUP && !flush)
                result <= is_rem_r ? r_fix : q_fix;
        end
    end

    // Datapath: operands captured on accept, one quotient bit per ITER cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_r    <= '0;
            quo_r    <= abs1;
            div_r    <= abs2;
            neg_q    <= is_signed && (op1_s[XLEN-1] ^ op2_s[XLEN-1]);
            neg_r    <= is_signed && op1_s[XLEN-1];
            is_rem_r <= is_rem;
        end else if (state == ITER) begin
            if (trial[XLEN]) begin
                rem_r <= shifted;
                quo_r <= {quo_r[XLEN-2:0], 1'b0};
            end else begin
                rem_r <= trial;
                quo_r <= {quo_r[XLEN-2:0], 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed vector bench for div_sequencer: result values, latency, stall and busy
// behaviour, plus hand sequences for ignored start, flush and async reset.
module tb_div_sequencer;
    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand1(operand1), .operand2(operand2), .flush(flush),
        .busy(busy), .stall(stall), .result_valid(result_valid), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          stl;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives a request at the current negedge (cycle N); returns at the N+1 negedge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int s0);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        #1 s0 = stall ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Scans cycles from N+k0 onward for the result_valid pulse, bounded at 40 cycles.
    task automatic wait_done(input int k0, output int lat, output logic [31:0] r, output int stl);
        lat = -1; r = '0; stl = 0;
        for (int k = k0; k <= k0 + 40; k++) begin
            #1;
            if (result_valid) begin
                lat = k; r = result;
                break;
            end
            if (stall) stl++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, lat, stl;
        logic [31:0] r;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         34, 34};
        vecs[1]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 34};
        vecs[2]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 34};
        vecs[3]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, 34};
        vecs[4]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1};
        vecs[5]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1,  1};
        vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1};
        vecs[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1};
        vecs[8]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 34};
        vecs[9]  = '{OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          34, 34};
        vecs[10] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  34, 34};
        vecs[11] = '{OP_DIVU, 32'h8000_0000,  32'd2,          32'h4000_0000,  34, 34};
        vecs[12] = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  34, 34};
        vecs[13] = '{OP_REMU, 32'd3,          32'd5,          32'd3,          34, 34};
        vecs[14] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 34};
        vecs[15] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34, 34};

        reset = 1'b1; start = 1'b1; flush = 1'b0; op = OP_DIV;
        operand1 = 32'd10; operand2 = 32'd2;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",   32'(busy),         32'd0);
        chk("rst_stall",  32'(stall),        32'd0);
        chk("rst_valid",  32'(result_valid), 32'd0);
        chk("rst_result", result,            32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        #1 chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, s0);
            wait_done(1, lat, r, stl);
            chk($sformatf("v%0d_result", i),  r,             vecs[i].exp);
            chk($sformatf("v%0d_latency", i), 32'(lat),      32'(vecs[i].lat));
            chk($sformatf("v%0d_stalls", i),  32'(s0 + stl), 32'(vecs[i].stl));
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_busy_after", i),  32'(busy),         32'd0);
            chk($sformatf("v%0d_valid_after", i), 32'(result_valid), 32'd0);
            chk($sformatf("v%0d_result_held", i), result,            vecs[i].exp);
        end

        // start during ITER must not disturb the running operation
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7, s0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_REM; operand1 = 32'd9; operand2 = 32'd4;
        #1 chk("ign_stall", 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat, r, stl);
        chk("ign_result",  r,        32'd14);
        chk("ign_latency", 32'(lat), 32'd34);

        // flush at N+10, then new request at N+11
        @(negedge clk);
        @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd3, s0);
        repeat (9) begin
            #1 chk("fl_no_valid", 32'(result_valid), 32'd0);
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        chk("fl_stall_n10", 32'(stall), 32'd1);
        chk("fl_busy_n10",  32'(busy),  32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_busy_n11",  32'(busy),         32'd0);
        chk("fl_valid_n11", 32'(result_valid), 32'd0);
        chk("fl_result",    result,            32'd14);
        issue(OP_DIVU, 32'd1000, 32'd3, s0);
        wait_done(1, lat, r, stl);
        chk("fl_next_result",  r,        32'd333);
        chk("fl_next_latency", 32'(lat), 32'd34);

        // flush in the same cycle as start blocks the accept
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_DIVU; operand1 = 32'd8; operand2 = 32'd2;
        #1 chk("fls_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("fls_busy",   32'(busy), 32'd0);
        chk("fls_result", result,    32'd333);

        // asynchronous reset mid-operation at N+20
        @(negedge clk);
        issue(OP_DIV, 32'd1000, 32'd3, s0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar_busy",   32'(busy),         32'd0);
        chk("ar_stall",  32'(stall),        32'd0);
        chk("ar_valid",  32'(result_valid), 32'd0);
        chk("ar_result", result,            32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(OP_DIV, 32'd42, 32'd6, s0);
        wait_done(1, lat, r, stl);
        chk("ar_next_result",  r,             32'd7);
        chk("ar_next_latency", 32'(lat),      32'd34);
        chk("ar_next_stalls",  32'(s0 + stl), 32'd34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
